// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//   Shared constants and types for the rf register file and the blocks that
//   read it.
//   Contents:
//     RF_BW, RF_DEPTH, RF_AW, RF_ACC_W : default operand width, file depth,
//                                        address width, accumulator width
//     state_t                          : dot-engine FSM states
//     operand_t / acc_t                : signed operand and accumulator types
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_BW    = 8;
    localparam int RF_DEPTH = 256;
    localparam int RF_AW    = $clog2(RF_DEPTH);
    // Wide enough that DEPTH full-scale products can never overflow.
    localparam int RF_ACC_W = 2 * RF_BW + RF_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic signed [RF_BW-1:0]    operand_t;
    typedef logic signed [RF_ACC_W-1:0] acc_t;

endpackage : rf_pkg

// File: rtl/rf_mac.sv
// -----------------------------------------------------------------------------
// rf_mac
//   Registered signed multiply-accumulate. Each enabled cycle adds a*b
//   (sign-extended to ACC_W) into the accumulator; clr zeroes it and takes
//   priority over en.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     clr           : clear accumulator on the next edge
//     en            : accumulate a*b on the next edge
//     a, b          : signed BW-bit operands
//     sum_next      : acc + a*b, i.e. the value the accumulator takes when en
// -----------------------------------------------------------------------------
module rf_mac
    import rf_pkg::*;
#(
    parameter int BW    = RF_BW,
    parameter int ACC_W = RF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [BW-1:0]    a,
    input  logic signed [BW-1:0]    b,
    output logic signed [ACC_W-1:0] sum_next
);

    logic signed [2*BW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // NOTE: every signal written in an always_comb gets a default on entry so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        prod     = a * b;
        prod_ext = {{(ACC_W - 2*BW){prod[2*BW-1]}}, prod};
        sum_next = acc_q + prod_ext;
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum_next;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : rf_mac

// File: rtl/rf_dot_engine.sv
// -----------------------------------------------------------------------------
// rf_dot_engine
//   Streams two operand vectors out of the rf register file through its two
//   synchronous read ports (one pair per cycle), computes their signed dot
//   product and presents it with a one-cycle done pulse.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     start                    : request a dot product (sampled in IDLE only)
//     base_a, base_b           : first addresses of vectors A and B
//     len                      : element count, values above DEPTH saturate
//     busy                     : high while RUN or DRAIN
//     done                     : one-cycle pulse when result updates
//     result                   : signed dot product, held until next done
//     rf_chip_en               : rf chip enable, high while busy
//     rf_read_addr_1/2         : A/B read addresses to rf
//     rf_data_out_1/2          : A/B read data from rf, one cycle after address
// -----------------------------------------------------------------------------
module rf_dot_engine
    import rf_pkg::*;
#(
    parameter int BW    = RF_BW,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int ACC_W = 2 * BW + AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [AW-1:0]           base_a,
    input  logic [AW-1:0]           base_b,
    input  logic [AW:0]             len,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] result,
    output logic                    rf_chip_en,
    output logic [AW-1:0]           rf_read_addr_1,
    output logic [AW-1:0]           rf_read_addr_2,
    input  logic signed [BW-1:0]    rf_data_out_1,
    input  logic signed [BW-1:0]    rf_data_out_2
);

    localparam int LW = AW + 1;

    state_t                  state_q,  state_d;
    logic [AW-1:0]           addr_a_q, addr_a_d;
    logic [AW-1:0]           addr_b_q, addr_b_d;
    logic [LW-1:0]           remain_q, remain_d;
    logic                    valid_q,  valid_d;
    logic                    done_q,   done_d;
    logic signed [ACC_W-1:0] result_q, result_d;

    logic [LW-1:0]           len_sat;
    logic                    mac_clr;
    logic                    mac_en;
    logic signed [ACC_W-1:0] mac_sum_next;

    // Requests longer than the file are clamped to one full pass.
    assign len_sat = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

    // -------------------------------------------------------------------------
    // State / datapath register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            remain_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            remain_q <= remain_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && (len_sat != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // remain_q counts pairs still to issue, including this one.
                if (remain_q == LW'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        remain_d = remain_q;
        result_d = result_q;
        done_d   = 1'b0;
        mac_clr  = 1'b0;
        // A pair issued this cycle has its rf data valid next cycle.
        valid_d  = (state_q == RUN);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_sat != '0) begin
                        addr_a_d = base_a;
                        addr_b_d = base_b;
                        remain_d = len_sat;
                        mac_clr  = 1'b1;
                    end else begin
                        result_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                // AW-bit counters wrap mod DEPTH on their own.
                addr_a_d = addr_a_q + AW'(1);
                addr_b_d = addr_b_q + AW'(1);
                remain_d = remain_q - LW'(1);
            end
            DRAIN: begin
                // The last product is on the rf outputs now; capture the
                // final sum directly so result and done appear together.
                result_d = mac_sum_next;
                done_d   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy       = (state_q != IDLE);
        rf_chip_en = (state_q != IDLE);
    end

    assign mac_en         = valid_q;
    assign done           = done_q;
    assign result         = result_q;
    assign rf_read_addr_1 = addr_a_q;
    assign rf_read_addr_2 = addr_b_q;

    rf_mac #(
        .BW    (BW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr),
        .en       (mac_en),
        .a        (rf_data_out_1),
        .b        (rf_data_out_2),
        .sum_next (mac_sum_next)
    );

endmodule : rf_dot_engine
